data_mem_bridge: RTL
====================

// Module: data_mem_bridge
// PURPOSE
//  MEM-stage data-memory bridge of the pipelined core, directly downstream of the pipeline datapath.
//  - Consumes the core request (address, write data, read/write enable, funct3 format).
//  - Issues single-outstanding word transactions on a valid/ready memory bus.
//  - Returns formatted load data and the two handshakes that drive want_stall_mem:
//    request_successful for stores, data_available for loads.
// PARAMETERS
//  TIMEOUT_CYCLES  256  bus cycles in REQ+RESP before forced completion; 0 = timeout disabled
// PORTS
//  clock                       in   1   clock
//  reset                       in   1   reset, asynchronous, active-high
//  core_address                in   32  byte address (alu_result of MEM stage)
//  core_write_data             in   32  store data (rs2 of MEM stage), unaligned, low bits valid
//  core_read_enable            in   1   load request
//  core_write_enable           in   1   store request
//  core_format                 in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_read_data              out  32  formatted load data, valid only while core_data_available=1
//  core_request_successful     out  1   store complete this cycle
//  core_data_available         out  1   load complete this cycle
//  bus_req_valid               out  1   bus request valid
//  bus_req_ready               in   1   bus accepts request
//  bus_req_write               out  1   1 = write, 0 = read
//  bus_req_addr                out  32  word address {addr[31:2],2'b00}
//  bus_req_wdata               out  32  lane-replicated write data
//  bus_req_strobe              out  4   byte-lane write enables (0000 for reads)
//  bus_resp_valid              in   1   read data valid; >=1 cycle after the request handshake
//  bus_resp_rdata              in   32  read word
//  access_error                out  1   1-cycle pulse: misaligned address, illegal format, or timeout
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; every output 0.
//  - Reset is asynchronous and may assert mid-transaction:
//    - bus_req_valid drops immediately.
//    - An outstanding response is dropped; the bus must be reset together with the bridge.
//  - FSM IDLE:
//    - A request is read_enable|write_enable; read has priority if both are set.
//    - Legal request: latch word address, strobe, replicated wdata, format and addr[1:0]; go to REQ.
//    - Illegal request completes in the same cycle, combinationally, with no bus activity:
//      - Illegal means H/HU with addr[0]=1, W with addr[1:0]!=0, or format 011/110/111.
//      - Outputs: access_error=1, done handshake=1, core_read_data=0.
//  - FSM REQ: bus_req_valid=1; all bus_req_* stay stable until bus_req_ready.
//    - Handshake on a write: core_request_successful=1 in that same cycle, then IDLE.
//    - Handshake on a read: go to RESP.
//  - FSM RESP: waits for bus_resp_valid.
//    - When it arrives: core_data_available=1 combinationally in the same cycle, core_read_data formatted, then IDLE.
//  - Completion contract: the datapath advances MEM at the edge that ends the completion cycle.
//    - IDLE treats inputs in the next cycle as a new request; the finished request is never reissued.
//  - Latency: store completes at the earliest in cycle 1 after presentation (IDLE cycle 0, REQ+ready cycle 1).
//    - Load data is available at the earliest in cycle 2.
//  - Write formatting:
//    - SB: strobe=0001<<addr[1:0], wdata={4{wd[7:0]}}.
//    - SH: strobe=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
//    - SW: strobe=1111, wdata=wd.
//  - Read formatting:
//    - B/BU: byte lane addr[1:0], sign- or zero-extended.
//    - H/HU: half lane addr[1], sign- or zero-extended.
//    - W: unchanged.
//  - Timeout:
//    - Counter clears on entering REQ and increments every cycle in REQ or RESP.
//    - At count==TIMEOUT_CYCLES-1 without completion: force completion.
//      Outputs that cycle: access_error=1, handshake=1, core_read_data=32'hDEADBEEF for loads, bus_req_valid=0 next cycle, then IDLE.
//    - A bus_req_ready arriving in that same cycle wins over the timeout, and the timeout does not fire.
//  - bus_resp_valid outside RESP is ignored.
//    - Known limitation: a response arriving late after a timeout, inside a later read's RESP, is accepted.
// TESTING
//  - SB: addr 0x1003, wd 0xA5, ready=1 at once.
//    Expect: req_addr 0x1000, strobe 1000, wdata 0xA5A5A5A5; request_successful in cycle 1 only, no reissue in cycle 2.
//  - LB: addr 0x2002; rdata 0x0080FF00 two cycles after the handshake.
//    Expect: data_available one cycle only, read_data 0xFFFFFF80. Same with LBU: 0x00000080.
//  - LH: addr 0x3001.
//    Expect: no bus_req_valid ever, access_error and data_available in cycle 0, read_data 0.
//  - Backpressure: SW with ready low for 5 cycles.
//    Expect: addr, wdata, strobe stable for 5 cycles; completion on the 6th REQ cycle.
//  - TIMEOUT_CYCLES=4, LW, resp never arrives.
//    Expect: at the 4th REQ/RESP cycle, access_error=1, data_available=1, read_data 0xDEADBEEF, then IDLE.
//  - Reset asserted in RESP.
//    Expect: outputs 0 immediately; a later resp_valid is ignored; the next LW completes normally.

Source files
------------

// File: rtl/data_mem_bridge.sv
// MEM-stage data-memory bridge: turns core load/store requests into single-outstanding
// word transactions on a valid/ready bus and returns formatted load data.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic        core_read_enable,
  input  logic        core_write_enable,
  input  logic [2:0]  core_format,
  output logic [31:0] core_read_data,
  output logic        core_request_successful,
  output logic        core_data_available,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_strobe,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  output logic        access_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    fmt_q;
  logic [1:0]    lane_q;

  logic        request;
  logic        legal;
  logic        timeout_hit;
  logic [3:0]  strobe_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign request = core_read_enable | core_write_enable;

  always_comb begin
    legal = 1'b0;
    case (core_format)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~core_address[0];
      3'b010:         legal = (core_address[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    strobe_next = 4'b1111;
    wdata_next  = core_write_data;
    case (core_format[1:0])
      2'b00: begin
        strobe_next = 4'b0001 << core_address[1:0];
        wdata_next  = {4{core_write_data[7:0]}};
      end
      2'b01: begin
        strobe_next = core_address[1] ? 4'b1100 : 4'b0011;
        wdata_next  = {2{core_write_data[15:0]}};
      end
      default: begin
        strobe_next = 4'b1111;
        wdata_next  = core_write_data;
      end
    endcase
  end

  // Halfword accesses are 2-byte aligned, so shifting by the full lane also selects the half.
  assign shifted = bus_resp_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data = bus_resp_rdata;
    case (fmt_q[1:0])
      2'b00:   load_data = {{24{shifted[7] & ~fmt_q[2]}}, shifted[7:0]};
      2'b01:   load_data = {{16{shifted[15] & ~fmt_q[2]}}, shifted[15:0]};
      default: load_data = bus_resp_rdata;
    endcase
  end

  assign timeout_hit = TIMEOUT_ON && (state == REQ || state == RESP) && (count == LAST);

  // Completion handshakes are combinational so the datapath can advance in the same cycle.
  always_comb begin
    core_read_data          = '0;
    core_request_successful = 1'b0;
    core_data_available     = 1'b0;
    access_error            = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (request && !legal) begin
            access_error = 1'b1;
            if (core_read_enable) core_data_available = 1'b1;
            else                  core_request_successful = 1'b1;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            if (bus_req_write) core_request_successful = 1'b1;
          end else if (timeout_hit) begin
            access_error = 1'b1;
            if (bus_req_write) begin
              core_request_successful = 1'b1;
            end else begin
              core_data_available = 1'b1;
              core_read_data      = 32'hDEADBEEF;
            end
          end
        end
        RESP: begin
          if (bus_resp_valid) begin
            core_data_available = 1'b1;
            core_read_data      = load_data;
          end else if (timeout_hit) begin
            access_error        = 1'b1;
            core_data_available = 1'b1;
            core_read_data      = 32'hDEADBEEF;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      fmt_q          <= '0;
      lane_q         <= '0;
      bus_req_valid  <= 1'b0;
      bus_req_write  <= 1'b0;
      bus_req_addr   <= '0;
      bus_req_wdata  <= '0;
      bus_req_strobe <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request && legal) begin
            state          <= REQ;
            count          <= '0;
            fmt_q          <= core_format;
            lane_q         <= core_address[1:0];
            bus_req_valid  <= 1'b1;
            bus_req_write  <= ~core_read_enable;
            bus_req_addr   <= {core_address[31:2], 2'b00};
            bus_req_wdata  <= core_read_enable ? '0 : wdata_next;
            bus_req_strobe <= core_read_enable ? '0 : strobe_next;
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= bus_req_write ? IDLE : RESP;
          end else if (timeout_hit) begin
            bus_req_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        RESP: begin
          count <= count + 1'b1;
          if (bus_resp_valid || timeout_hit) state <= IDLE;
        end
        default: begin
          bus_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
